// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and stall sequencer beside the ID stage; stall outputs are combinational (zero latency).
// mem_busy freezes the whole pipeline and holds the sequencer, a flush cancels any stall, and reset forces normal flow.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_mem_read,
    input  logic [REG_W-1:0] IDEX_regRd,
    input  logic [REG_W-1:0] IFID_regRs,
    input  logic [REG_W-1:0] IFID_regRt,
    input  logic             IFID_use_rs,
    input  logic             IFID_use_rt,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             mux_sel,
    output logic             pipe_freeze,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int REM_RAW = $clog2(LOAD_LAT + 1);
    localparam int REM_W   = (REM_RAW < 1) ? 1 : REM_RAW;
    localparam int REM_INI = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 0;

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_LU_STALL = 1'b1;

    logic [0:0]       r_state;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic w_rd_ok;
    logic w_src_match;
    logic w_hit;
    logic w_stall;

    // With ZERO_REG set, a load "into" register 0 writes nothing, so it cannot create a hazard.
    assign w_rd_ok     = (IDEX_regRd != '0) || (ZERO_REG == 0);
    assign w_src_match = (IFID_use_rs && (IFID_regRs == IDEX_regRd)) ||
                         (IFID_use_rt && (IFID_regRt == IDEX_regRd));
    assign w_hit       = IDEX_mem_read && (LOAD_LAT > 0) && w_rd_ok && w_src_match;
    assign w_stall     = (r_state == S_LU_STALL) || w_hit;

    always_comb begin
        pc_write    = 1'b1;
        IFID_write  = 1'b1;
        mux_sel     = 1'b1;
        pipe_freeze = 1'b0;
        if (rst) begin
            pc_write = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            IFID_write  = 1'b0;
            pipe_freeze = 1'b1;
        end else if (flush) begin
            pc_write = 1'b1;
        end else if (w_stall) begin
            pc_write   = 1'b0;
            IFID_write = 1'b0;
            mux_sel    = 1'b0;
        end
    end

    assign stall_active = !rst && (r_state == S_LU_STALL);
    assign stall_cnt    = rst ? '0 : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else begin
            if (!pc_write && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A frozen pipeline keeps the sequencer exactly where it was.
            if (!mem_busy) begin
                if (flush) begin
                    r_state <= S_IDLE;
                    r_rem   <= '0;
                end else if (r_state == S_LU_STALL) begin
                    if (r_rem <= REM_W'(1)) begin
                        r_state <= S_IDLE;
                        r_rem   <= '0;
                    end else begin
                        r_rem <= r_rem - 1'b1;
                    end
                end else if (w_hit && (LOAD_LAT > 1)) begin
                    r_state <= S_LU_STALL;
                    r_rem   <= REM_W'(REM_INI);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Two differently parameterised instances share one stimulus stream; each is compared every cycle to a
// bubble-count model (LOAD_LAT=3/ZERO_REG=1/CNT_W=16 and LOAD_LAT=1/ZERO_REG=0/CNT_W=2).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst, mem_read, use_rs, use_rt, mem_busy, flush;
    logic [4:0] rd, rs, rt;

    logic        pcw [2];
    logic        ifw [2];
    logic        msel[2];
    logic        frz [2];
    logic        sact[2];
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int checks   = 0;
    int failures = 0;

    int lat [2] = '{3, 1};
    int zr  [2] = '{1, 0};
    int cmax[2] = '{65535, 3};
    int s_left[2];
    int s_cnt [2];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .ZERO_REG(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .IDEX_mem_read(mem_read), .IDEX_regRd(rd),
        .IFID_regRs(rs), .IFID_regRt(rt), .IFID_use_rs(use_rs), .IFID_use_rt(use_rt),
        .mem_busy(mem_busy), .flush(flush), .pc_write(pcw[0]), .IFID_write(ifw[0]),
        .mux_sel(msel[0]), .pipe_freeze(frz[0]), .stall_active(sact[0]), .stall_cnt(cnt_a)
    );

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG(0), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .IDEX_mem_read(mem_read), .IDEX_regRd(rd),
        .IFID_regRs(rs), .IFID_regRt(rt), .IFID_use_rs(use_rs), .IFID_use_rt(use_rt),
        .mem_busy(mem_busy), .flush(flush), .pc_write(pcw[1]), .IFID_write(ifw[1]),
        .mux_sel(msel[1]), .pipe_freeze(frz[1]), .stall_active(sact[1]), .stall_cnt(cnt_b)
    );

    task automatic check(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[dut%0d] observed=%0d expected=%0d", tag, i, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare settled outputs, then advance the model.
    task automatic cyc(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s,
                       input logic [4:0] t, input logic urs, input logic urt,
                       input logic mb, input logic fl);
        logic hit, e_pc, e_ifw, e_mux, e_frz, e_act;
        int   e_cnt;
        @(negedge clk);
        rst = r; mem_read = mr; rd = d; rs = s; rt = t;
        use_rs = urs; use_rt = urt; mem_busy = mb; flush = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            hit = mr && (lat[i] > 0) && ((d != 0) || (zr[i] == 0)) &&
                  ((urs && (s == d)) || (urt && (t == d)));
            e_act = !r && (s_left[i] > 0);
            e_cnt = r ? 0 : s_cnt[i];
            {e_pc, e_ifw, e_mux, e_frz} = 4'b1110;
            if (r) begin
                s_left[i] = 0;
                s_cnt[i]  = 0;
            end else if (mb) begin
                {e_pc, e_ifw, e_mux, e_frz} = 4'b0011;
            end else if (fl) begin
                s_left[i] = 0;
            end else if (s_left[i] > 0) begin
                {e_pc, e_ifw, e_mux, e_frz} = 4'b0000;
                s_left[i] = s_left[i] - 1;
            end else if (hit) begin
                {e_pc, e_ifw, e_mux, e_frz} = 4'b0000;
                s_left[i] = lat[i] - 1;
            end
            if (!r && !e_pc && (s_cnt[i] < cmax[i])) s_cnt[i] = s_cnt[i] + 1;
            check("pc_write",     i, 32'(pcw[i]),  32'(e_pc));
            check("IFID_write",   i, 32'(ifw[i]),  32'(e_ifw));
            check("mux_sel",      i, 32'(msel[i]), 32'(e_mux));
            check("pipe_freeze",  i, 32'(frz[i]),  32'(e_frz));
            check("stall_active", i, 32'(sact[i]), 32'(e_act));
            check("stall_cnt",    i, (i == 0) ? 32'(cnt_a) : 32'(cnt_b), 32'(e_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_left[i] = 0;
            s_cnt[i]  = 0;
        end
        cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        cyc(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        // Load r5 feeding Rs
        cyc(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
        idle(4);
        // Load r7 feeding Rt
        cyc(0, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0, 0);
        idle(4);
        // Register 0 exemption and unused-source qualification
        cyc(0, 1, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0);
        idle(3);
        cyc(0, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0);
        idle(2);
        // mem_busy for two cycles in the second stall cycle
        cyc(0, 1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0);
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        idle(4);
        // Flush in the second stall cycle
        cyc(0, 1, 5'd6, 5'd6, 5'd0, 1, 0, 0, 0);
        cyc(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        idle(3);
        // Hit together with flush, and hit together with mem_busy
        cyc(0, 1, 5'd2, 5'd2, 5'd0, 1, 0, 0, 1);
        cyc(0, 1, 5'd2, 5'd2, 5'd0, 1, 0, 1, 0);
        idle(4);
        // Reset mid-stall
        cyc(0, 1, 5'd8, 5'd0, 5'd8, 0, 1, 0, 0);
        cyc(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        idle(3);
        // Back-to-back hits to drive the 2-bit counter into saturation
        for (int k = 0; k < 6; k++) cyc(0, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0);
        idle(3);
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
